seq_controller: RTL

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller_if.sv | 23 ++
 rtl/seq_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_controller_if.sv
// Handshake bundle between seq_controller, its requester and its slave channels.
interface seq_controller_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              start;
  logic              mode;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] trigger;
  logic              busy;
  logic              finished;
  logic              timeout_err;
  logic [3:0]        err_ch;

  modport master (
    output start, mode, done,
    input  trigger, busy, finished, timeout_err, err_ch
  );

  modport slave (
    input  start, mode, done,
    output trigger, busy, finished, timeout_err, err_ch
  );
endinterface

// File: rtl/seq_controller.sv
// Run controller: fires slave channels one at a time or all together, waits for their
// done pulses with an optional per-trigger timeout, then reports completion.
module seq_controller #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, FINISH, ERROR} state_t;

  localparam logic [NUM_CH-1:0] ALL  = '1;
  localparam logic [NUM_CH-1:0] ONE  = NUM_CH'(1);
  localparam logic [3:0]        LAST = 4'(NUM_CH - 1);

  state_t            r_state, w_state_nx;
  logic              r_mode, w_mode_nx;
  logic [3:0]        r_cur, w_cur_nx;
  logic [NUM_CH-1:0] r_mask, w_mask_nx;
  logic [NUM_CH-1:0] r_trig, w_trig_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_terr, w_terr_nx;
  logic [3:0]        r_errch, w_errch_nx;
  logic [NUM_CH-1:0] w_acc;
  logic [3:0]        w_low;
  logic              w_low_found;
  logic              w_seq_done;
  logic              w_tmo;

  assign w_acc      = r_mask | bus.done;
  assign w_seq_done = |(bus.done & (ONE << r_cur));
  // The trigger cycle counts as cycle 0, so the last cycle that still accepts done is TIMEOUT-1.
  assign w_tmo      = (TIMEOUT != 0) && (32'(r_cnt) >= TIMEOUT - 1);

  always_comb begin
    w_low       = '0;
    w_low_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_acc[i] && !w_low_found) begin
        w_low       = 4'(i);
        w_low_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_cur_nx   = r_cur;
    w_mask_nx  = r_mask;
    w_cnt_nx   = r_cnt;
    w_trig_nx  = '0;
    w_terr_nx  = r_terr;
    w_errch_nx = r_errch;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx = TRIG;
          w_mode_nx  = bus.mode;
          w_cur_nx   = '0;
          w_mask_nx  = '0;
          w_cnt_nx   = '0;
          w_terr_nx  = 1'b0;
          w_errch_nx = '0;
          w_trig_nx  = bus.mode ? ALL : ONE;
        end
      end
      TRIG, WAIT: begin
        w_state_nx = WAIT;
        w_cnt_nx   = r_cnt + 1'b1;
        if (!r_mode) begin
          if (w_seq_done) begin
            if (r_cur == LAST) begin
              w_state_nx = FINISH;
            end else begin
              w_state_nx = TRIG;
              w_cur_nx   = r_cur + 4'd1;
              w_cnt_nx   = '0;
              w_trig_nx  = ONE << (r_cur + 4'd1);
            end
          end else if (w_tmo) begin
            w_state_nx = ERROR;
            w_terr_nx  = 1'b1;
            w_errch_nx = r_cur;
          end
        end else begin
          w_mask_nx = w_acc;
          if (&w_acc) begin
            w_state_nx = FINISH;
          end else if (w_tmo) begin
            w_state_nx = ERROR;
            w_terr_nx  = 1'b1;
            w_errch_nx = w_low;
          end
        end
      end
      FINISH, ERROR: w_state_nx = IDLE;
      default:       w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_cur   <= '0;
      r_mask  <= '0;
      r_trig  <= '0;
      r_cnt   <= '0;
      r_terr  <= 1'b0;
      r_errch <= '0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_cur   <= w_cur_nx;
      r_mask  <= w_mask_nx;
      r_trig  <= w_trig_nx;
      r_cnt   <= w_cnt_nx;
      r_terr  <= w_terr_nx;
      r_errch <= w_errch_nx;
    end
  end

  assign bus.trigger     = r_trig;
  assign bus.busy        = (r_state != IDLE);
  assign bus.finished    = (r_state == FINISH) || (r_state == ERROR);
  assign bus.timeout_err = r_terr;
  assign bus.err_ch      = r_errch;
endmodule
